sram_arbiter: RTL and testbench

Single-port controller for the external 256K×16 asynchronous SRAM that the logging buffer lives in. It arbitrates between the sensor-data write stream and the `read_buffer` word fetches, and generates SRAM strobe timing. It owns the circular write pointer, exported as `WRITE_ADDRESS`, and returns fetched words as `DATA_READ`. It sits between the logging/downlink datapath and the SRAM pins.

---
 rtl/sram_pkg.sv | 9 +
 rtl/sram_wait_counter.sv | 18 +
 rtl/sram_arbiter.sv | 110 +++++++++++
 tb/tb_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and sizes for the external SRAM controller
package sram_pkg;
   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;
   localparam int DEFAULT_ACCESS_CYCLES = 3;
   typedef enum logic [2:0] {
      IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, RD_LATCH
   } state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that flags when it has reached zero
module sram_wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         done
);
   logic [W-1:0] cnt;
   // take a fresh count on load, otherwise run down to zero and park there
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign done = cnt == '0;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: write-stream / read-fetch arbiter and strobe sequencer for the async log SRAM
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES,
   parameter int ADDR_WIDTH = SRAM_ADDR_W,
   parameter int DATA_WIDTH = SRAM_DATA_W
) (
   input  logic                  CLK_48MHZ,
   input  logic                  RESET,
   input  logic                  WRITE_REQ,
   input  logic [DATA_WIDTH-1:0] WRITE_DATA,
   output logic                  WRITE_ACK,
   output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
   input  logic                  READ_CMD,
   input  logic [ADDR_WIDTH-1:0] READ_ADDRESS,
   output logic [DATA_WIDTH-1:0] DATA_READ,
   output logic                  READ_VALID,
   output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
   output logic [DATA_WIDTH-1:0] SRAM_DQ_OUT,
   input  logic [DATA_WIDTH-1:0] SRAM_DQ_IN,
   output logic                  SRAM_DQ_OE,
   output logic                  SRAM_CE_N,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_OE_N
);
   localparam int CW = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(ACCESS_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(ACCESS_CYCLES > 1 ? ACCESS_CYCLES - 2 : 0);

   state_t state, state_next;
   logic last_rd, rd_pending, grant_wr, grant_rd, cnt_done, reading;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

   assign WRITE_ADDRESS = wr_addr;
   assign reading = state inside {RD_SETUP, RD_WAIT, RD_LATCH};
   assign grant_wr = WRITE_REQ && (!rd_pending || last_rd);
   assign grant_rd = rd_pending && !grant_wr;

   sram_wait_counter #(.W(CW)) u_wait (
      .clk   (CLK_48MHZ),
      .rst_n (RESET),
      .load  (state == WR_SETUP || state == RD_SETUP),
      .value (state == WR_SETUP ? PULSE_LOAD : WAIT_LOAD),
      .done  (cnt_done)
   );

   // state register; reset aborts any access in flight
   always_ff @(posedge CLK_48MHZ or negedge RESET)
      if (!RESET) state <= IDLE;
      else state <= state_next;

   // sequencing: every access returns to IDLE for at least one cycle of bus turnaround
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     state_next = grant_wr ? WR_SETUP : grant_rd ? RD_SETUP : IDLE;
         WR_SETUP: state_next = WR_PULSE;
         WR_PULSE: state_next = cnt_done ? WR_HOLD : WR_PULSE;
         WR_HOLD:  state_next = IDLE;
         RD_SETUP: state_next = ACCESS_CYCLES == 1 ? RD_LATCH : RD_WAIT;
         RD_WAIT:  state_next = cnt_done ? RD_LATCH : RD_WAIT;
         RD_LATCH: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // single-entry read latch plus round-robin memory of the last granted type
   always_ff @(posedge CLK_48MHZ or negedge RESET)
      if (!RESET) begin
         rd_pending <= 1'b0;
         rd_addr <= '0;
         last_rd <= 1'b1;
      end else begin
         if (state == IDLE && grant_rd) rd_pending <= 1'b0;
         else if (READ_CMD && !rd_pending && !reading) begin
            rd_pending <= 1'b1;
            rd_addr <= READ_ADDRESS;
         end
         if (state == IDLE && (grant_wr || grant_rd)) last_rd <= grant_rd;
      end

   // outputs are registered from the next state so pins change cleanly on the clock
   always_ff @(posedge CLK_48MHZ or negedge RESET)
      if (!RESET) begin
         wr_addr <= '0;
         DATA_READ <= '0;
         WRITE_ACK <= 1'b0;
         READ_VALID <= 1'b0;
         SRAM_CE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_DQ_OE <= 1'b0;
         SRAM_ADDR <= '0;
         SRAM_DQ_OUT <= '0;
      end else begin
         wr_addr <= state == WR_HOLD ? wr_addr + 1'b1 : wr_addr;
         WRITE_ACK <= state_next == WR_HOLD;
         READ_VALID <= state == RD_LATCH;
         SRAM_CE_N <= state_next == IDLE;
         SRAM_WE_N <= state_next != WR_PULSE;
         SRAM_OE_N <= !(state_next inside {RD_SETUP, RD_WAIT, RD_LATCH});
         SRAM_DQ_OE <= state_next inside {WR_SETUP, WR_PULSE, WR_HOLD};
         if (state == RD_LATCH) DATA_READ <= SRAM_DQ_IN;
         if (state == IDLE && grant_wr) begin
            SRAM_ADDR <= wr_addr;
            SRAM_DQ_OUT <= WRITE_DATA;
         end else if (state == IDLE && grant_rd) SRAM_ADDR <= rd_addr;
      end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter against a behavioural async SRAM
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic RESET, WRITE_REQ, WRITE_ACK, READ_CMD, READ_VALID;
   logic SRAM_DQ_OE, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;
   logic [15:0] WRITE_DATA, DATA_READ, SRAM_DQ_OUT, SRAM_DQ_IN;
   logic [17:0] WRITE_ADDRESS, READ_ADDRESS, SRAM_ADDR;

   logic [15:0] mem [0:262143];
   logic pl_en = 1'b0;
   logic [17:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   int n_checks = 0, n_fail = 0;
   logic [15:0] exp_q [$];
   bit glog [$];
   int we_run = 0, last_we_len = 0, n_ack = 0, bad_idle = 0;
   logic [17:0] we_addr = '0;
   logic prev_ce = 1'b1;
   logic [17:0] wr_ptr = '0;

   sram_arbiter dut (
      .CLK_48MHZ     (clk),
      .RESET         (RESET),
      .WRITE_REQ     (WRITE_REQ),
      .WRITE_DATA    (WRITE_DATA),
      .WRITE_ACK     (WRITE_ACK),
      .WRITE_ADDRESS (WRITE_ADDRESS),
      .READ_CMD      (READ_CMD),
      .READ_ADDRESS  (READ_ADDRESS),
      .DATA_READ     (DATA_READ),
      .READ_VALID    (READ_VALID),
      .SRAM_ADDR     (SRAM_ADDR),
      .SRAM_DQ_OUT   (SRAM_DQ_OUT),
      .SRAM_DQ_IN    (SRAM_DQ_IN),
      .SRAM_DQ_OE    (SRAM_DQ_OE),
      .SRAM_CE_N     (SRAM_CE_N),
      .SRAM_WE_N     (SRAM_WE_N),
      .SRAM_OE_N     (SRAM_OE_N)
   );

   always #5 clk = ~clk;

   // async SRAM model: writes while CE/WE are low, drives data while CE/OE are low
   always @(posedge clk)
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ_OUT;
   assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // bus monitor: WE pulse width, access order, idle strobes, ack count, read scoreboard
   always @(negedge clk) begin
      if (!SRAM_WE_N) begin
         we_run <= we_run + 1;
         if (we_run == 0) we_addr <= SRAM_ADDR;
      end else if (we_run != 0) begin
         last_we_len <= we_run;
         we_run <= 0;
      end
      prev_ce <= SRAM_CE_N;
      if (!SRAM_CE_N && prev_ce) glog.push_back(SRAM_DQ_OE);
      if ((SRAM_CE_N && (!SRAM_WE_N || !SRAM_OE_N || SRAM_DQ_OE)) || (!SRAM_OE_N && SRAM_DQ_OE))
         bad_idle <= 1;
      if (WRITE_ACK) n_ack <= n_ack + 1;
      if (READ_VALID) begin
         if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
         else check("read_data", DATA_READ, exp_q.pop_front());
      end
   end

   task automatic preload(input logic [17:0] a, input logic [15:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] d);
      int n = 0;
      logic got = 1'b0;
      logic [17:0] a = wr_ptr;
      WRITE_REQ = 1'b1;
      WRITE_DATA = d;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = WRITE_ACK;
      end
      WRITE_REQ = 1'b0;
      check("wr_ack_lat", n, 5);
      @(negedge clk);
      check("wr_we_len", last_we_len, 3);
      check("wr_sram_addr", we_addr, a);
      wr_ptr = wr_ptr + 1'b1;
      check("wr_next_addr", WRITE_ADDRESS, wr_ptr);
      check("wr_mem", mem[a], d);
   endtask

   task automatic do_read(input logic [17:0] a);
      int n = 0;
      logic got = 1'b0, dq = 1'b0;
      logic [31:0] ra = 32'hFFFF_FFFF;
      READ_CMD = 1'b1;
      READ_ADDRESS = a;
      exp_q.push_back(mem[a]);
      while (!got && n < 40) begin
         @(negedge clk);
         READ_CMD = 1'b0;
         n++;
         if (SRAM_DQ_OE) dq = 1'b1;
         if (!SRAM_OE_N) ra = 32'(SRAM_ADDR);
         got = READ_VALID;
      end
      check("rd_valid_lat", n, 6);
      check("rd_dq_oe", dq, 0);
      check("rd_sram_addr", ra, 32'(a));
      @(negedge clk);
      check("rd_q_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, acks, valids, nv, ack0;
      logic bad;
      logic [7:0] pat;
      RESET = 1'b0;
      WRITE_REQ = 1'b0;
      WRITE_DATA = '0;
      READ_CMD = 1'b0;
      READ_ADDRESS = '0;
      repeat (3) @(negedge clk);
      check("rst_wr_addr", WRITE_ADDRESS, 0);
      check("rst_data_read", DATA_READ, 0);
      check("rst_ack_valid", {WRITE_ACK, READ_VALID}, 0);
      check("rst_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 4'b1110);
      check("rst_sram_addr", SRAM_ADDR, 0);
      check("rst_dq_out", SRAM_DQ_OUT, 0);
      RESET = 1'b1;
      @(negedge clk);

      do_write(16'hA5A5);
      for (int i = 0; i < 14; i++) do_write(16'h0100 + 16'(i));
      do_write(16'h1234);
      do_read(18'h0000F);

      for (int i = 0; i < 2; i++) exp_q.push_back(mem[15]);
      glog.delete();
      acks = 0;
      valids = 0;
      n = 0;
      READ_ADDRESS = 18'h0000F;
      READ_CMD = 1'b1;
      WRITE_REQ = 1'b1;
      WRITE_DATA = 16'h5555;
      while ((acks < 2 || valids < 2) && n < 100) begin
         @(negedge clk);
         n++;
         if (WRITE_ACK) begin
            acks++;
            WRITE_DATA = 16'hAAAA;
            if (acks == 2) WRITE_REQ = 1'b0;
         end
         if (READ_VALID) begin
            valids++;
            if (valids == 2) READ_CMD = 1'b0;
         end
      end
      WRITE_REQ = 1'b0;
      READ_CMD = 1'b0;
      repeat (2) @(negedge clk);
      pat = '0;
      for (int i = 0; i < glog.size(); i++) pat = {pat[6:0], glog[i]};
      check("alt_count", glog.size(), 4);
      check("alt_order", pat, 8'b0000_1010);
      check("alt_mem0", mem[18'h10], 16'h5555);
      check("alt_mem1", mem[18'h11], 16'hAAAA);
      wr_ptr = wr_ptr + 18'd2;
      check("alt_wr_addr", WRITE_ADDRESS, wr_ptr);
      check("alt_q_empty", exp_q.size(), 0);

      preload(18'h00050, 16'hBEEF);
      preload(18'h00100, 16'hCAFE);
      READ_ADDRESS = 18'h00050;
      READ_CMD = 1'b1;
      exp_q.push_back(mem[18'h00050]);
      nv = 0;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) READ_CMD = 1'b0;
         if (i == 2) begin
            check("dr_in_flight", SRAM_OE_N, 0);
            READ_ADDRESS = 18'h00100;
            READ_CMD = 1'b1;
         end
         if (i == 3) READ_CMD = 1'b0;
         if (READ_VALID) nv++;
         if (!SRAM_OE_N && SRAM_ADDR == 18'h00100) bad = 1'b1;
      end
      check("dr_valid_count", nv, 1);
      check("dr_second_ignored", bad, 0);
      check("dr_q_empty", exp_q.size(), 0);

      WRITE_REQ = 1'b1;
      WRITE_DATA = 16'h9999;
      n = 0;
      while (SRAM_WE_N && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_pulse", SRAM_WE_N, 0);
      ack0 = n_ack;
      #2 RESET = 1'b0;
      #1;
      check("rst_mid_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 4'b1110);
      check("rst_mid_wr_addr", WRITE_ADDRESS, 0);
      WRITE_REQ = 1'b0;
      repeat (3) @(negedge clk);
      RESET = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_mid_no_ack", n_ack, ack0);
      wr_ptr = '0;
      do_write(16'h4242);
      do_read(18'h00000);

      force dut.wr_addr = 18'h3FFFF;
      @(negedge clk);
      release dut.wr_addr;
      @(negedge clk);
      check("wrap_preload", WRITE_ADDRESS, 18'h3FFFF);
      wr_ptr = 18'h3FFFF;
      do_write(16'h7777);
      check("wrap_zero", WRITE_ADDRESS, 0);

      check("strobes_idle_ok", bad_idle, 0);
      check("final_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
